mem_access_ctrl: RTL and testbench

- Multi-cycle data-memory sequencer between the RV32I core's load/store path and a word-wide, single-port data memory with variable latency.
- Consumes the decoder's memory-write strobe and 3-bit Size code, plus the ALU address and rs2 data.
- Performs word accesses directly and sub-word stores as read-modify-write.
- Returns sign/zero-extended load data and stalls the core until the access completes.

---
 rtl/rv_mem_pkg.sv | 28 ++
 rtl/mem_access_ctrl_lane_align.sv | 35 +++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared load/store size codes and data-memory sequencer state encoding.
// The size codes match the Size output of the control unit.
package rv_mem_pkg;

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_HS = 3'b001;
    localparam logic [2:0] SZ_HU = 3'b010;
    localparam logic [2:0] SZ_BS = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_e;

    // An illegal size code, or an address that is not aligned to the access size.
    function automatic logic req_bad(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SZ_W:         req_bad = (lo != 2'b00);
            SZ_HS, SZ_HU: req_bad = lo[0];
            SZ_BS, SZ_BU: req_bad = 1'b0;
            default:      req_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte/half lane steering: merges store data into a read word and
// extracts the sign/zero-extended load value from it.
module lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] merged,
    output logic [31:0] ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte  = rword[{addr_lo, 3'b000} +: 8];
        rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];
        merged = rword;
        ext    = rword;
        case (size)
            SZ_BS, SZ_BU: begin
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                ext = (size == SZ_BS) ? {{24{rbyte[7]}}, rbyte} : {24'h000000, rbyte};
            end
            SZ_HS, SZ_HU: begin
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                ext = (size == SZ_HS) ? {{16{rhalf[15]}}, rhalf} : {16'h0000, rhalf};
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer for a single-port, variable-latency word memory.
// Sub-word stores are performed as read-modify-write.
module mem_access_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic            done_q, err_q, mem_req_q, mem_we_q, write_q;
    logic [2:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic [31:0]     wdata_q, rdata_q, mem_wdata_q;
    logic [29:0]     mem_addr_q;
    logic [TO_W-1:0] cnt_q;
    logic [31:0]     merged, ext;

    lane_align u_lane (
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .wdata   (wdata_q),
        .rword   (mem_rdata),
        .merged  (merged),
        .ext     (ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= SZ_W;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    write_q    <= req_write;
                    size_q     <= req_size;
                    addr_lo_q  <= req_addr[1:0];
                    wdata_q    <= req_wdata;
                    mem_addr_q <= req_addr[31:2];
                    cnt_q      <= '0;
                    if (req_bad(req_size, req_addr[1:0])) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (!req_write || req_size != SZ_W) begin
                        state_q   <= ST_RD;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end else begin
                        state_q     <= ST_WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= req_wdata;
                    end
                end
                // mem_ack is tested before the timeout so a late ack still completes normally.
                ST_RD: if (mem_ack) begin
                    cnt_q <= '0;
                    if (write_q) begin
                        state_q     <= ST_WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged;
                    end else begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        rdata_q   <= ext;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_q   <= ST_DONE;
                    mem_req_q <= 1'b0;
                    rdata_q   <= '0;
                    done_q    <= 1'b1;
                    err_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + TO_W'(1);
                end
                ST_WR: if (mem_ack) begin
                    state_q   <= ST_DONE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    done_q    <= 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_q   <= ST_DONE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    rdata_q   <= '0;
                    done_q    <= 1'b1;
                    err_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + TO_W'(1);
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_IDLE && req_valid);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model predicts every
// cycle's outputs, plus literal checks on key results.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_size = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, busy_cnt = 0, req_cnt = 0;
    logic [31:0] last_wd = '0;

    logic        chk_en = 1'b0;
    logic        e_busy, e_done, e_err, e_req, e_we;
    logic [29:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] m_rdata = '0;

    mem_access_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Loaded value as the architecture defines it: shift the lane down, then extend.
    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] sz, input logic [1:0] lo);
        logic [31:0] v;
        case (sz)
            3'd1, 3'd2: begin
                v = (w >> (16 * int'(lo[1]))) & 32'h0000FFFF;
                if (sz == 3'd1 && v >= 32'h00008000) v = v + 32'hFFFF0000;
            end
            3'd3, 3'd4: begin
                v = (w >> (8 * int'(lo))) & 32'h000000FF;
                if (sz == 3'd3 && v >= 32'h00000080) v = v + 32'hFFFFFF00;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [2:0] sz, input logic [1:0] lo);
        logic [31:0] mask;
        int sh;
        if (sz == 3'd3 || sz == 3'd4) begin
            mask = 32'h000000FF;
            sh   = 8 * int'(lo);
        end else begin
            mask = 32'h0000FFFF;
            sh   = 16 * int'(lo[1]);
        end
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("done", {31'b0, done}, {31'b0, e_done});
            chk("err", {31'b0, err}, {31'b0, e_err});
            chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
            chk("rdata", rdata, m_rdata);
            if (e_req) begin
                chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                chk("mem_addr", {2'b0, mem_addr}, {2'b0, e_addr});
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (busy) busy_cnt++;
            if (mem_req) req_cnt++;
            if (mem_req && mem_we) last_wd = mem_wdata;
            if (done) done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic b, input logic d, input logic e, input logic r,
                           input logic we, input logic [29:0] a, input logic [31:0] wd);
        e_busy = b; e_done = d; e_err = e; e_req = r; e_we = we; e_addr = a; e_wdata = wd;
    endtask

    task automatic idle(input logic spur_ack);
        step();
        req_valid = 1'b0;
        mem_ack   = spur_ack;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One memory phase: wt idle cycles then ack (wt<0: never); gives up after TO cycles.
    task automatic phase(input int wt, input logic we, input logic [31:0] a,
                         input logic [31:0] wexp, output logic tmo);
        tmo = 1'b0;
        for (int k = 0; k < TO; k++) begin
            step();
            mem_ack = (k == wt);
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, we, a[31:2], wexp);
            if (k == wt) return;
        end
        tmo = 1'b1;
    endtask

    task automatic txn(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mw, input int rw, input int ww);
        logic bad, tmo;
        logic [31:0] wexp;
        bad  = (sz > 3'd4) || (sz == 3'd0 && a[1:0] != 2'b00) || ((sz == 3'd1 || sz == 3'd2) && a[0]);
        tmo  = 1'b0;
        wexp = (sz == 3'd0) ? wd : m_merge(mw, wd, sz, a[1:0]);
        step();
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        mem_ack = 1'b0; mem_rdata = mw;
        acc_cyc = cyc; busy_cnt = 0; req_cnt = 0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a[31:2], wexp);
        if (!bad && (!w || sz != 3'd0)) phase(rw, 1'b0, a, wexp, tmo);
        if (!bad && w && !tmo) phase(ww, 1'b1, a, wexp, tmo);
        step();
        mem_ack = 1'b0;
        if (tmo) m_rdata = '0;
        else if (!bad && !w) m_rdata = m_ext(mw, sz, a[1:0]);
        set_exp(1'b0, 1'b1, bad | tmo, 1'b0, 1'b0, a[31:2], wexp);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk_en = 1'b1;
        idle(1'b0);

        txn(1'b0, 3'd0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 3, 0);
        chk("wl_rdata", rdata, 32'hDEADBEEF);
        chk("wl_addr", {2'b0, mem_addr}, 32'h0000_0040);
        chk("wl_busy_cycles", busy_cnt, 32'd5);
        idle(1'b1);

        txn(1'b0, 3'd3, 32'h0000_0103, 32'h0, 32'h80FF0011, 0, 0);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        txn(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF0011, 0, 0);
        chk("lbu_rdata", rdata, 32'h00000080);

        txn(1'b1, 3'd3, 32'h0000_0102, 32'h0000_00AB, 32'h11223344, 0, 0);
        chk("sb_latency", done_cyc - acc_cyc, 32'd3);
        chk("sb_wdata", last_wd, 32'h11AB3344);
        chk("sb_rdata_kept", rdata, 32'h00000080);

        txn(1'b0, 3'd1, 32'h0000_0101, 32'h0, 32'h12345678, 0, 0);
        chk("mis_no_req", req_cnt, 32'd0);
        chk("mis_latency", done_cyc - acc_cyc, 32'd1);
        txn(1'b0, 3'd5, 32'h0000_0100, 32'h0, 32'h12345678, 0, 0);
        chk("badsz_no_req", req_cnt, 32'd0);
        txn(1'b0, 3'd0, 32'h0000_0102, 32'h0, 32'h12345678, 0, 0);

        txn(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h80011234, 2, 0);
        chk("lh_rdata", rdata, 32'hFFFF8001);
        txn(1'b1, 3'd2, 32'h0000_0100, 32'h1234BEEF, 32'h11223344, 1, 2);
        chk("sh_wdata", last_wd, 32'h1122BEEF);
        txn(1'b1, 3'd0, 32'h0000_0204, 32'hCAFEF00D, 32'h0, 0, 0);
        chk("sw_latency", done_cyc - acc_cyc, 32'd2);

        txn(1'b1, 3'd0, 32'h0000_0200, 32'h55AA55AA, 32'h0, 0, -1);
        chk("to_req_cycles", req_cnt, 32'd4);
        chk("to_rdata", rdata, 32'd0);
        txn(1'b1, 3'd0, 32'h0000_0204, 32'h01020304, 32'h0, 0, 3);
        chk("late_ack_req_cycles", req_cnt, 32'd4);
        txn(1'b0, 3'd0, 32'h0000_0104, 32'h0, 32'hA5A5_0F0F, 0, 0);

        step();
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'd0; req_addr = 32'h0000_0180; mem_ack = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h60, '0);
        step();
        set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'h60, '0);
        step();
        #2;
        chk_en = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rstrd_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstrd_busy", {31'b0, busy}, 32'd0);
        chk("rstrd_done", {31'b0, done}, 32'd0);
        chk("rstrd_rdata", rdata, 32'd0);
        step();
        step();
        reset = 1'b0;
        m_rdata = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk_en = 1'b1;

        txn(1'b0, 3'd0, 32'h0000_0300, 32'h0, 32'h12345678, 1, 0);
        chk("post_rst_rdata", rdata, 32'h12345678);
        idle(1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
